// File: rtl/adxl362_cntrl.sv
// ADXL362 register-access sequencer: expands one register read/write request into
// the three-byte command/address/data SPI transaction with CS held across bytes.
module adxl362_cntrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  CMD_WRITE      = 8'h0A,
  parameter logic [7:0]  CMD_READ       = 8'h0B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] data_to_send,
  output logic [7:0] data_received,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       spi_start,
  output logic [7:0] spi_data_to_send,
  output logic       spi_hold_cs,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_data_received
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    state;
  logic [1:0]    idx;
  logic          wr_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          abort_q;
  logic [CW-1:0] wdog;
  logic [CW-1:0] wdog_next;

  // Saturating watchdog increment; abort is decided on the incremented value.
  always_comb begin
    wdog_next = wdog;
    if (wdog != {CW{1'b1}}) wdog_next = wdog + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= 2'd0;
      wr_q             <= 1'b0;
      addr_q           <= 8'h00;
      wdata_q          <= 8'h00;
      abort_q          <= 1'b0;
      wdog             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      spi_start        <= 1'b0;
      spi_hold_cs      <= 1'b0;
      spi_data_to_send <= 8'h00;
      data_received    <= 8'h00;
    end else begin
      spi_start <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_q    <= write;
            addr_q  <= address;
            wdata_q <= data_to_send;
            idx     <= 2'd0;
            abort_q <= 1'b0;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            wdog      <= '0;
            state     <= S_WAIT;
            case (idx)
              2'd0: begin
                spi_data_to_send <= wr_q ? CMD_WRITE : CMD_READ;
                spi_hold_cs      <= 1'b1;
              end
              2'd1: begin
                spi_data_to_send <= addr_q;
                spi_hold_cs      <= 1'b1;
              end
              default: begin
                spi_data_to_send <= wr_q ? wdata_q : 8'h00;
                spi_hold_cs      <= 1'b0;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            if (idx == 2'd2) begin
              if (!wr_q) data_received <= spi_data_received;
              state <= S_FINISH;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_ISSUE;
            end
          end else if (wdog_next == CW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled engine: release CS and report through the normal finish path.
            spi_hold_cs <= 1'b0;
            abort_q     <= 1'b1;
            state       <= S_FINISH;
          end else begin
            wdog <= wdog_next;
          end
        end
        default: begin
          done  <= 1'b1;
          error <= abort_q;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adxl362_cntrl.sv
// Self-checking bench for adxl362_cntrl: randomized-latency SPI byte engine model
// plus a transaction-level reference for bytes, CS hold, read data and timing.
module tb_adxl362_cntrl;

  localparam int         TMO   = 16;
  localparam logic [7:0] CMD_W = 8'h0A;
  localparam logic [7:0] CMD_R = 8'h0B;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       write;
  logic [7:0] address;
  logic [7:0] data_to_send;
  logic [7:0] data_received;
  logic       busy;
  logic       done;
  logic       error;
  logic       spi_start;
  logic [7:0] spi_data_to_send;
  logic       spi_hold_cs;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_data_received;

  adxl362_cntrl #(.TIMEOUT_CYCLES(TMO), .CMD_WRITE(CMD_W), .CMD_READ(CMD_R)) dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
    .data_to_send(data_to_send), .data_received(data_received), .busy(busy),
    .done(done), .error(error), .spi_start(spi_start),
    .spi_data_to_send(spi_data_to_send), .spi_hold_cs(spi_hold_cs),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_data_received(spi_data_received)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       h;
    int         c;
  } ent_t;

  ent_t       log_q[$];
  int         cyc = 0;
  int         starts_seen = 0;
  int         hang_count = -1;
  int         last_done_cyc = 0;
  logic [7:0] resp_byte = 8'h00;
  logic [7:0] model_rx = 8'h00;
  int         errors = 0;
  int         checks = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (spi_start === 1'b1) starts_seen <= starts_seen + 1;

  // Byte engine: logs each request, answers after 1..6 cycles, or stalls when armed.
  initial begin
    int   lat;
    ent_t e;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_data_received = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (spi_start === 1'b1) begin
        e.b = spi_data_to_send;
        e.h = spi_hold_cs;
        e.c = cyc;
        log_q.push_back(e);
        if (hang_count == 0) begin
          hang_count = -1;
        end else begin
          if (hang_count > 0) hang_count--;
          spi_busy = 1'b1;
          lat = $urandom_range(1, 6);
          repeat (lat) @(negedge clk);
          spi_data_received = spi_hold_cs ? 8'($urandom) : resp_byte;
          spi_done = 1'b1;
          spi_busy = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_txn(input string name, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] resp,
                         input bit imm, input bit poke);
    int         c0;
    int         s0;
    bit         got;
    logic [7:0] exp_b[3];
    logic       exp_h[3];
    log_q.delete();
    s0 = starts_seen;
    if (!imm) @(negedge clk);
    start = 1'b1; write = w; address = a; data_to_send = d; resp_byte = resp;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0; write = 1'($urandom); address = 8'($urandom); data_to_send = 8'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/done after start: got %b/%b want 1/0", name, busy, done);
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (poke && i == 4) begin start = 1'b1; write = 1'b1; address = 8'h3F; end
        if (poke && i == 5) start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done timeout: got no done want done within 300 cycles", name);
      return;
    end
    if (!w) model_rx = resp;
    exp_b = '{(w ? CMD_W : CMD_R), a, (w ? d : 8'h00)};
    exp_h = '{1'b1, 1'b1, 1'b0};
    checks++;
    if ({error, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s error/busy at done: got %b/%b want 0/0", name, error, busy);
    end
    checks++;
    if (cyc !== last_done_cyc + 2) begin
      errors++;
      $display("FAIL %s done latency: got cycle %0d want %0d", name, cyc, last_done_cyc + 2);
    end
    checks++;
    if (log_q.size() !== 3 || starts_seen - s0 !== 3) begin
      errors++;
      $display("FAIL %s byte count: got %0d logged/%0d pulses want 3", name, log_q.size(),
               starts_seen - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_q[i].b !== exp_b[i] || log_q[i].h !== exp_h[i]) begin
          errors++;
          $display("FAIL %s byte%0d: got %h hold=%b want %h hold=%b", name, i, log_q[i].b,
                   log_q[i].h, exp_b[i], exp_h[i]);
        end
      end
      checks++;
      if (log_q[0].c !== c0 + 2) begin
        errors++;
        $display("FAIL %s first spi_start latency: got %0d want 2", name, log_q[0].c - c0);
      end
    end
    checks++;
    if (data_received !== model_rx) begin
      errors++;
      $display("FAIL %s data_received: got %h want %h", name, data_received, model_rx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; write = 1'b0; address = 8'h00; data_to_send = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, spi_start, spi_hold_cs, spi_data_to_send, data_received} !== 21'd0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b err=%b ss=%b hold=%b tx=%h rx=%h want all 0",
               busy, done, error, spi_start, spi_hold_cs, spi_data_to_send, data_received);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 8'h2D, 8'h02, 8'h77, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 8'h00, 8'h00, 8'hAD, 1'b0, 1'b0);
    run_txn("hold_after_write", 1'b1, 8'h20, 8'h5A, 8'h11, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b1, 8'h2C, 8'h13, 8'h00, 1'b0, 1'b0);
    run_txn("b2b_second", 1'b0, 8'h01, 8'h00, 8'h1D, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    int n = 0;
    run_txn("ignored_start", 1'b1, 8'h10, 8'h55, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || spi_start === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL ignored_start extra activity: got %0d cycles want 0", n);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      run_txn("random", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              (k % 3 == 1), 1'b0);
  endtask

  task automatic test_timeout();
    bit got = 1'b0;
    hang_count = 1;
    log_q.delete();
    @(negedge clk);
    start = 1'b1; write = 1'b0; address = 8'($urandom); resp_byte = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout done: got no done want done after watchdog");
      return;
    end
    checks++;
    if ({error, busy, spi_hold_cs} !== 3'b100) begin
      errors++;
      $display("FAIL timeout flags: got err=%b busy=%b hold=%b want 1/0/0", error, busy, spi_hold_cs);
    end
    checks++;
    if (log_q.size() !== 2 || cyc !== log_q[log_q.size()-1].c + TMO) begin
      errors++;
      $display("FAIL timeout latency: got %0d bytes, done at +%0d want 2 bytes, +%0d",
               log_q.size(), cyc - log_q[log_q.size()-1].c, TMO);
    end
    checks++;
    if (data_received !== model_rx) begin
      errors++;
      $display("FAIL timeout data_received: got %h want %h", data_received, model_rx);
    end
    @(negedge clk);
    checks++;
    if ({done, error} !== 2'b00) begin
      errors++;
      $display("FAIL timeout pulse width: got done=%b err=%b want 0/0", done, error);
    end
    hang_count = -1;
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    int n = 0;
    log_q.delete();
    @(negedge clk);
    start = 1'b1; write = 1'b1; address = 8'h2D; data_to_send = 8'h02;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (log_q.size() >= 2) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_mid reach idx1: got %0d bytes want 2", log_q.size());
    end
    #2 rst = 1'b1;
    #1;
    model_rx = 8'h00;
    checks++;
    if ({busy, done, error, spi_start, spi_hold_cs, spi_data_to_send, data_received} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid async outputs: got busy=%b ss=%b hold=%b tx=%h rx=%h want all 0",
               busy, spi_start, spi_hold_cs, spi_data_to_send, data_received);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_mid done pulses: got %0d want 0", n);
    end
    run_txn("after_reset", 1'b0, 8'h0B, 8'h00, 8'h42, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignored_start();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
